mem_wb_multi: RTL and testbench
===============================

# mem_wb_multi

Parametrised MEM/WB pipeline register for the multi-issue core. It carries up to `LANES` register-file write requests and one HI/LO write from the memory-access stage to write-back on each clock edge. It adds to the single-lane stage register:
- flush handling
- per-lane valid bits
- masking of same-bundle register write conflicts and $0 writes
- a retired-instruction counter

It sits between the memory-access stage and the register file / HI-LO unit. Its outputs also feed the forwarding network.

## Interface
Parameters:
- `DATA_W`, 32, data width of register and HI/LO values
- `ADDR_W`, 5, register address width
- `LANES`, 2, issue lanes (1..4); lane 0 is the oldest instruction in the bundle
- `STAGE`, 4, index of this stage in the stall vector (0..4)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  6  stall vector from the controller; `stall[STAGE]`: MEM stalled, `stall[STAGE+1]`: WB stalled
- `flush`  in  1  kill the bundle entering WB (exception/ERET)
- `mem_valid`  in  LANES  lane holds a real instruction
- `mem_wd`  in  LANES*ADDR_W  destination register per lane; lane i occupies bits [i*ADDR_W +: ADDR_W]
- `mem_wreg`  in  LANES  write enable per lane
- `mem_wdata`  in  LANES*DATA_W  write data per lane
- `mem_hi`, `mem_lo`  in  DATA_W  HI/LO values
- `mem_whilo`  in  1  HI/LO write enable
- `wb_valid`, `wb_wd`, `wb_wreg`, `wb_wdata`  out  same widths as inputs  registered lane outputs
- `wb_hi`, `wb_lo`  out  DATA_W  registered HI/LO
- `wb_whilo`  out  1  registered HI/LO enable
- `retire_cnt`  out  32  count of instructions passed to WB

## Operation
Per edge, the first matching case applies:
1. **Reset** (`rst`=1): every output goes to 0, including `retire_cnt`.
2. **Flush** (`flush`=1): bubble. Outputs go to 0 and `retire_cnt` holds. Flush overrides every stall combination.
3. **Bubble** (`stall[STAGE]`=Stop and `stall[STAGE+1]`=NoStop): outputs go to 0 and `retire_cnt` holds.
4. **Capture** (`stall[STAGE]`=NoStop): load the sanitised inputs. Add popcount(`mem_valid`) to `retire_cnt`.
5. **Hold** (both stall bits Stop): all outputs and `retire_cnt` keep their values.

Sanitising, applied on capture:
- Effective lane write enable = `mem_wreg[i] & mem_valid[i] & (mem_wd[i] != 0)`.
- Conflicts: if an older lane i and a younger lane j (i<j) both have an effective write to the same register, clear lane i's write enable. The youngest write wins. Lane i's data and address are still registered.
- An invalid lane registers zeros in `wb_wd` and `wb_wdata`.
- Effective `wb_whilo` = `mem_whilo & |mem_valid`.

`retire_cnt` wraps modulo 2^32 (0xFFFFFFFF + 1 → 0). No saturation.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on `wb_*` after edge N.
- There is no combinational path from input to output.
- `stall` and `flush` are sampled on the same edge as the data.
- If reset is asserted mid-stall, the next edge clears all outputs; stall is ignored.
- After reset deasserts, the first edge with `stall[STAGE]`=NoStop captures normally.
- A held bundle is written to the register file again on each hold cycle. This is harmless because the data is identical.

## Structure
- Use the constants `RstEnable`, `Stop`, `NoStop`, `WriteDisable`, `ZeroWord` from `defines.v`. Add `RetireCntBus` (31:0) there.
- Sub-module `mem_wb_lane`: one lane's register with inputs rst/flush/bubble/capture/hold and a pre-sanitised enable. Instantiate it in a generate loop over `LANES`.
- The top level holds:
  - conflict masking, as combinational logic before the lanes
  - the HI/LO registers
  - the popcount function
  - `retire_cnt`

## Test plan
- **Reset then capture.** Apply `rst`=1, then release it. Drive lane0 = {valid, wd=3, wreg, 0x11}, lane1 = {valid, wd=4, wreg, 0x22}, stall=0. Expect both lanes written to WB and `retire_cnt`=2.
- **Same-register conflict.** Drive both lanes with wd=7 and wreg=1. Expect `wb_wreg`=2'b10 with lane1's data. Repeat with wd=0 on both lanes: expect `wb_wreg`=00.
- **Stall patterns.**
  - stall=6'b011111 (bit4 Stop, bit5 NoStop): expect outputs 0 for one cycle and `retire_cnt` unchanged.
  - stall=6'b111111: expect outputs frozen at the prior values for 3 cycles.
- **Flush priority.** Assert `flush`=1 together with stall=6'b111111. Expect outputs 0 after the edge and `retire_cnt` unchanged.
- **HI/LO write.** Drive `mem_whilo`=1, hi=0xDEAD, lo=0xBEEF, with `mem_valid`=00 and then 01. Expect `wb_whilo`=0 and then `wb_whilo`=1 with the values passed through.
- **Counter wrap.** Force `retire_cnt` to 0xFFFFFFFF via a backdoor, then capture two valid lanes. Expect `retire_cnt`=1.

Source files
------------

// File: rtl/mem_wb_multi_pkg.sv
// Shared constants for the MEM/WB stage register.
//   RstEnable / Stop / NoStop / WriteDisable : control-level encodings
//   ZeroWord                                  : 32-bit zero
//   RetireCntBus                              : retired-instruction counter type
package mem_wb_multi_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    typedef logic [31:0] RetireCntBus;

endpackage

// File: rtl/mem_wb_multi_lane.sv
// One issue lane of the MEM/WB stage register.
//   clk, rst       : clock, synchronous active-high reset
//   flush, bubble  : load zeros (flush has priority over bubble)
//   capture, hold  : load the incoming lane / keep the current contents
//   valid, wd, wreg_eff, wdata : lane inputs; wreg_eff is already conflict-masked
//   wb_valid, wb_wd, wb_wreg, wb_wdata : registered lane outputs
module mem_wb_multi_lane
    import mem_wb_multi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              bubble,
    input  logic              capture,
    input  logic              hold,
    input  logic              valid,
    input  logic [ADDR_W-1:0] wd,
    input  logic              wreg_eff,
    input  logic [DATA_W-1:0] wdata,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata
);

    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush || bubble) begin
            wb_valid <= 1'b0;
            wb_wd    <= '0;
            wb_wreg  <= WriteDisable;
            wb_wdata <= '0;
        end else if (capture) begin
            // An invalid lane carries no address or data into WB.
            wb_valid <= valid;
            wb_wd    <= valid ? wd : '0;
            wb_wreg  <= wreg_eff;
            wb_wdata <= valid ? wdata : '0;
        end else if (hold) begin
            wb_valid <= wb_valid;
            wb_wd    <= wb_wd;
            wb_wreg  <= wb_wreg;
            wb_wdata <= wb_wdata;
        end
    end

endmodule

// File: rtl/mem_wb_multi.sv
// Multi-issue MEM/WB pipeline register.
//   clk, rst        : clock, synchronous active-high reset
//   stall[5:0]      : stall[STAGE] = MEM stalled, stall[STAGE+1] = WB stalled
//   flush           : kill the bundle entering WB
//   mem_valid/wd/wreg/wdata : per-lane inputs, lane i at [i*W +: W]
//   mem_hi/lo/whilo : HI/LO write request
//   wb_*            : registered outputs toward register file / HI-LO / forwarding
//   retire_cnt      : running count of instructions passed to WB (wraps)
module mem_wb_multi
    import mem_wb_multi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 2,
    parameter int STAGE  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               stall,
    input  logic                     flush,
    input  logic [LANES-1:0]         mem_valid,
    input  logic [LANES*ADDR_W-1:0]  mem_wd,
    input  logic [LANES-1:0]         mem_wreg,
    input  logic [LANES*DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]        mem_hi,
    input  logic [DATA_W-1:0]        mem_lo,
    input  logic                     mem_whilo,
    output logic [LANES-1:0]         wb_valid,
    output logic [LANES*ADDR_W-1:0]  wb_wd,
    output logic [LANES-1:0]         wb_wreg,
    output logic [LANES*DATA_W-1:0]  wb_wdata,
    output logic [DATA_W-1:0]        wb_hi,
    output logic [DATA_W-1:0]        wb_lo,
    output logic                     wb_whilo,
    output RetireCntBus              retire_cnt
);

    function automatic RetireCntBus popcount(input logic [LANES-1:0] v);
        RetireCntBus n;
        n = ZeroWord;
        for (int k = 0; k < LANES; k++) begin
            n = n + RetireCntBus'(v[k]);
        end
        return n;
    endfunction

    logic mem_stop;
    logic wb_stop;
    logic bubble;
    logic capture;
    logic hold;

    assign mem_stop = (stall[STAGE]   == Stop);
    assign wb_stop  = (stall[STAGE+1] == Stop);
    assign bubble   = mem_stop & ~wb_stop;
    assign capture  = ~mem_stop;
    assign hold     = mem_stop & wb_stop;

    logic [LANES-1:0] wreg_eff;
    logic [LANES-1:0] wreg_masked;

    // Youngest writer of a register wins; $0 writes and invalid lanes never write.
    always_comb begin
        wreg_eff    = '0;
        wreg_masked = '0;
        for (int i = 0; i < LANES; i++) begin
            wreg_eff[i] = mem_wreg[i] & mem_valid[i] &
                          (mem_wd[i*ADDR_W +: ADDR_W] != '0);
        end
        wreg_masked = wreg_eff;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (wreg_eff[i] && wreg_eff[j] &&
                    (mem_wd[i*ADDR_W +: ADDR_W] == mem_wd[j*ADDR_W +: ADDR_W])) begin
                    wreg_masked[i] = 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mem_wb_multi_lane #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .bubble   (bubble),
            .capture  (capture),
            .hold     (hold),
            .valid    (mem_valid[g]),
            .wd       (mem_wd[g*ADDR_W +: ADDR_W]),
            .wreg_eff (wreg_masked[g]),
            .wdata    (mem_wdata[g*DATA_W +: DATA_W]),
            .wb_valid (wb_valid[g]),
            .wb_wd    (wb_wd[g*ADDR_W +: ADDR_W]),
            .wb_wreg  (wb_wreg[g]),
            .wb_wdata (wb_wdata[g*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wb_hi      <= '0;
            wb_lo      <= '0;
            wb_whilo   <= WriteDisable;
            retire_cnt <= ZeroWord;
        end else if (flush || bubble) begin
            wb_hi    <= '0;
            wb_lo    <= '0;
            wb_whilo <= WriteDisable;
        end else if (capture) begin
            // HI/LO values always travel; only the enable depends on a live lane.
            wb_hi      <= mem_hi;
            wb_lo      <= mem_lo;
            wb_whilo   <= mem_whilo & (|mem_valid);
            retire_cnt <= retire_cnt + popcount(mem_valid);
        end
    end

endmodule

// File: tb/tb_mem_wb_multi.sv
module tb_mem_wb_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [1:0]  mem_valid;
    logic [9:0]  mem_wd;
    logic [1:0]  mem_wreg;
    logic [63:0] mem_wdata;
    logic [31:0] mem_hi, mem_lo;
    logic        mem_whilo;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_wd;
    logic [1:0]  wb_wreg;
    logic [63:0] wb_wdata;
    logic [31:0] wb_hi, wb_lo;
    logic        wb_whilo;
    logic [31:0] retire_cnt;

    always #5 clk = ~clk;

    mem_wb_multi #(.DATA_W(32), .ADDR_W(5), .LANES(2), .STAGE(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_whilo(mem_whilo), .wb_valid(wb_valid), .wb_wd(wb_wd),
        .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .wb_whilo(wb_whilo), .retire_cnt(retire_cnt)
    );

    typedef struct packed {
        logic [1:0]  v;
        logic [9:0]  wd;
        logic [1:0]  wreg;
        logic [63:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step%0d %s got %h expected %h", step_no, name, act, exp);
        end
    endtask

    // Monitor: after each edge, compare the DUT against the oldest pending expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            step_no++;
            cmp("wb_valid",   64'(wb_valid),   64'(e.v));
            cmp("wb_wd",      64'(wb_wd),      64'(e.wd));
            cmp("wb_wreg",    64'(wb_wreg),    64'(e.wreg));
            cmp("wb_wdata",   wb_wdata,        e.wdata);
            cmp("wb_hi",      64'(wb_hi),      64'(e.hi));
            cmp("wb_lo",      64'(wb_lo),      64'(e.lo));
            cmp("wb_whilo",   64'(wb_whilo),   64'(e.whilo));
            cmp("retire_cnt", 64'(retire_cnt), 64'(e.cnt));
        end
    end

    function automatic exp_t mk(input logic [1:0] v, input logic [9:0] wd,
                                input logic [1:0] wreg, input logic [63:0] wdata,
                                input logic [31:0] hi, input logic [31:0] lo,
                                input logic whilo, input logic [31:0] cnt);
        exp_t e;
        e.v = v; e.wd = wd; e.wreg = wreg; e.wdata = wdata;
        e.hi = hi; e.lo = lo; e.whilo = whilo; e.cnt = cnt;
        return e;
    endfunction

    task automatic step(input bit bd, input logic r, input logic f, input logic [5:0] s,
                        input logic [1:0] v, input logic [9:0] wd, input logic [1:0] wr,
                        input logic [63:0] wdat, input logic wh, input logic [31:0] hi,
                        input logic [31:0] lo, input exp_t e);
        @(negedge clk);
        if (bd) dut.retire_cnt = 32'hFFFF_FFFF;
        rst = r; flush = f; stall = s;
        mem_valid = v; mem_wd = wd; mem_wreg = wr; mem_wdata = wdat;
        mem_whilo = wh; mem_hi = hi; mem_lo = lo;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = '0; mem_valid = '0; mem_wd = '0;
        mem_wreg = '0; mem_wdata = '0; mem_hi = '0; mem_lo = '0; mem_whilo = 1'b0;

        // reset, then reset while stalled
        step(0, 1, 0, 6'b000000, 2'b11, 10'h083, 2'b11, 64'h22_00000011, 1, 32'h5, 32'h6,
             mk(2'b00, 10'h000, 2'b00, 64'h0, 32'h0, 32'h0, 0, 32'd0));
        step(0, 1, 0, 6'b111111, 2'b11, 10'h083, 2'b11, 64'h22_00000011, 1, 32'h5, 32'h6,
             mk(2'b00, 10'h000, 2'b00, 64'h0, 32'h0, 32'h0, 0, 32'd0));
        // first capture: lane0 $3=0x11, lane1 $4=0x22
        step(0, 0, 0, 6'b000000, 2'b11, 10'h083, 2'b11, 64'h22_00000011, 0, 32'h0, 32'h0,
             mk(2'b11, 10'h083, 2'b11, 64'h22_00000011, 32'h0, 32'h0, 0, 32'd2));
        // both lanes write $7: older lane masked
        step(0, 0, 0, 6'b000000, 2'b11, 10'h0E7, 2'b11, 64'hB0_000000A0, 0, 32'h0, 32'h0,
             mk(2'b11, 10'h0E7, 2'b10, 64'hB0_000000A0, 32'h0, 32'h0, 0, 32'd4));
        // both lanes write $0: no write enables
        step(0, 0, 0, 6'b000000, 2'b11, 10'h000, 2'b11, 64'h2_00000001, 0, 32'h0, 32'h0,
             mk(2'b11, 10'h000, 2'b00, 64'h2_00000001, 32'h0, 32'h0, 0, 32'd6));
        // lane1 invalid: zeroed address/data/enable
        step(0, 0, 0, 6'b000000, 2'b01, 10'h125, 2'b11, 64'h99_00000055, 1, 32'h1, 32'h2,
             mk(2'b01, 10'h005, 2'b01, 64'h55, 32'h1, 32'h2, 1, 32'd7));
        // bubble: MEM stalled, WB running
        step(0, 0, 0, 6'b011111, 2'b11, 10'h083, 2'b11, 64'h22_00000011, 1, 32'h7, 32'h8,
             mk(2'b00, 10'h000, 2'b00, 64'h0, 32'h0, 32'h0, 0, 32'd7));
        // lane0 invalid, lane1 $6=0x66
        step(0, 0, 0, 6'b000000, 2'b10, 10'h0C8, 2'b11, 64'h66_00000088, 1, 32'h3, 32'h4,
             mk(2'b10, 10'h0C0, 2'b10, 64'h66_00000000, 32'h3, 32'h4, 1, 32'd8));
        // hold for three cycles with changing inputs
        step(0, 0, 0, 6'b111111, 2'b11, 10'h022, 2'b11, 64'hFF_000000FF, 0, 32'h9, 32'h9,
             mk(2'b10, 10'h0C0, 2'b10, 64'h66_00000000, 32'h3, 32'h4, 1, 32'd8));
        step(0, 0, 0, 6'b111111, 2'b01, 10'h3FF, 2'b01, 64'h1_00000001, 1, 32'hA, 32'hB,
             mk(2'b10, 10'h0C0, 2'b10, 64'h66_00000000, 32'h3, 32'h4, 1, 32'd8));
        step(0, 0, 0, 6'b111111, 2'b11, 10'h083, 2'b11, 64'h22_00000011, 1, 32'hC, 32'hD,
             mk(2'b10, 10'h0C0, 2'b10, 64'h66_00000000, 32'h3, 32'h4, 1, 32'd8));
        // flush beats a full stall
        step(0, 0, 1, 6'b111111, 2'b11, 10'h083, 2'b11, 64'h22_00000011, 1, 32'hC, 32'hD,
             mk(2'b00, 10'h000, 2'b00, 64'h0, 32'h0, 32'h0, 0, 32'd8));
        // HI/LO with no valid lane: enable dropped, values pass
        step(0, 0, 0, 6'b000000, 2'b00, 10'h083, 2'b11, 64'h22_00000011, 1, 32'hDEAD, 32'hBEEF,
             mk(2'b00, 10'h000, 2'b00, 64'h0, 32'hDEAD, 32'hBEEF, 0, 32'd8));
        // HI/LO with lane0 valid
        step(0, 0, 0, 6'b000000, 2'b01, 10'h000, 2'b00, 64'h99_00000077, 1, 32'hDEAD, 32'hBEEF,
             mk(2'b01, 10'h000, 2'b00, 64'h77, 32'hDEAD, 32'hBEEF, 1, 32'd9));
        // counter preloaded to all-ones, two lanes retire -> wraps to 1
        step(1, 0, 0, 6'b000000, 2'b11, 10'h041, 2'b11, 64'hB_0000000A, 0, 32'h0, 32'h0,
             mk(2'b11, 10'h041, 2'b11, 64'hB_0000000A, 32'h0, 32'h0, 0, 32'd1));
        // reset clears the counter
        step(0, 1, 0, 6'b111111, 2'b11, 10'h041, 2'b11, 64'hB_0000000A, 1, 32'h1, 32'h1,
             mk(2'b00, 10'h000, 2'b00, 64'h0, 32'h0, 32'h0, 0, 32'd0));

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
